imem_fill: RTL and testbench
============================

# imem_fill

Line-fill engine between the L1 instruction cache refill port and the 64-bit system memory bus. It accepts a block-address read request from `imem` and issues the sequential beat reads needed for one cache line. It assembles the beats and returns the whole line to `imem` with a single-cycle valid pulse. An optional next-line prefetch buffer hides sequential-miss latency.

## Interface
- `BLK_LEN`, 59: block address width; must equal `` `IMEM_BLK_LEN ``.
- `LINE`, 256: cache line width in bits; must equal `` `IMEM_LINE ``.
- `BEAT`, 64: memory bus data width. `LINE/BEAT` is a power of two, ≥2.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `b_addr_i` in `BLK_LEN`: requested block address; stable while `b_rd_i` is high.
- `b_rd_i` in 1: line read request; level, held until `b_dv_i`.
- `b_data_i` out `LINE`: returned line; valid only while `b_dv_i`=1.
- `b_dv_i` out 1: line valid, one-cycle pulse.
- `m_addr` out 64: beat byte address, `BEAT/8`-aligned.
- `m_rd` out 1: beat read request; level.
- `m_data` in `BEAT`: beat data; valid while `m_ack`=1.
- `m_ack` in 1: beat accepted and data valid, one-cycle pulse.

## Operation
- N = `LINE/BEAT` beats per line; beat index k has width log2(N).
- Beat k address: `m_addr = {blk, k, log2(BEAT/8)'b0}`. Beats are issued in order k = 0..N-1, with no wrap or critical-word ordering.
- Beat k data is stored at `line[BEAT*k +: BEAT]`.
- States:
  - IDLE
  - FILL: `m_rd`=1
  - RESP: `b_dv_i`=1
  - HOLD: `b_rd_i` is ignored, because `imem` drops it the cycle after `b_dv_i`
  - PF: prefetch fill, only with the macro enabled
- IDLE → FILL when `b_rd_i`=1 and no prefetch hit. `b_addr_i` is latched into `blk` and k is cleared.
- In FILL, each `m_ack` stores `m_data` and increments k. `m_addr` advances on the same edge and `m_rd` stays high.
- On the `m_ack` with k = N-1, FILL → RESP and `m_rd`=0 on the next cycle.
- RESP lasts exactly one cycle and drives `b_data_i` = assembled line. Then RESP → HOLD.
- HOLD → IDLE, or → PF when prefetch is enabled.
- `b_data_i` holds its last value outside RESP. The verification environment must not check it outside RESP.
- `m_addr` holds its last value when `m_rd`=0.
- `m_ack` while `m_rd`=0 is a bus protocol violation and is ignored.

## Timing
- Reset values: `b_dv_i`=0, `b_data_i`=0, `m_rd`=0, `m_addr`=0, state=IDLE, k=0, prefetch valid=0.
- Reset takes effect immediately (asynchronous), including mid-fill. Any partial line is discarded and no `b_dv_i` is produced.
- Cycle 0: `b_rd_i` is sampled high in IDLE.
- Cycle 1: `m_rd`=1 with beat 0.
- With zero-wait memory, `m_ack` occurs in cycles 1..N and `b_dv_i`=1 in cycle N+1.
- Miss latency is N+1 cycles plus the memory wait cycles.
- `b_rd_i` arriving during HOLD is not accepted. It is accepted in the next IDLE cycle.
- A `b_addr_i` change while `b_rd_i`=1 during FILL is ignored; the latched `blk` is used.

## Configuration
- Macro `IMEM_FILL_PREFETCH_EN`.
- **Defined:**
  - After HOLD, the engine fills block `blk+1` into a separate prefetch buffer (PF state, same beat rules) and sets `pf_v` with `pf_blk`.
  - No prefetch is started if `blk` is all ones; the address never wraps to 0.
  - **Prefetch hit:** `b_rd_i` in IDLE with `pf_v` and `b_addr_i == pf_blk`. The engine goes IDLE → RESP with the buffer contents; `b_dv_i` is at cycle 1. The hit block becomes `blk`, then prefetch of `blk+1` follows.
  - **Request during PF, same block:** PF completes, then RESP directly; no refetch.
  - **Request during PF, different block:** the outstanding beat completes (`m_rd` held until `m_ack`). The prefetch is then discarded (`pf_v`=0) and FILL of the demand block starts on the following cycle.
- **Undefined:** no PF state and no prefetch buffer. HOLD → IDLE always.

## Test plan
- **Reset, then a miss (N=4, zero-wait):** `b_rd_i`=1, `b_addr_i`=0x10.
  - `m_addr` = 0x200, 0x208, 0x210, 0x218 in cycles 1..4.
  - `b_dv_i`=1 in cycle 5 only, with `b_data_i` = {beat3, beat2, beat1, beat0}.
- **Memory wait states:** `m_ack` delayed by 3 cycles per beat → `m_addr` stays stable while waiting; `b_dv_i` in cycle 17.
- **Reset mid-fill:** `rst_n`=0 after beat 1 → `m_rd`=0 and `b_dv_i`=0 immediately. A new request for 0x20 after release fetches from 0x400 starting at beat 0.
- **Back-to-back requests:** `b_rd_i` reasserted in HOLD → it is not accepted until IDLE, and exactly one `b_dv_i` occurs per request.
- **Prefetch hit (`IMEM_FILL_PREFETCH_EN`):** miss on 0x10, wait for PF to finish, then request 0x11 → `b_dv_i` the next cycle with no `m_rd` for 0x11. PF of 0x12 follows.
- **Prefetch abort (`IMEM_FILL_PREFETCH_EN`):** request 0x40 during PF of 0x11 → the current beat completes, then `m_addr` = 0x800. `pf_v`=0; a later request for 0x11 misses.

Source files
------------

// File: rtl/imem_fill.sv
// rtl/imem_fill.sv - L1 instruction cache line-fill engine over a 64-bit memory bus
// Optional next-line prefetch buffer enabled by `IMEM_FILL_PREFETCH_EN.
module imem_fill #(
  parameter int BLK_LEN = 59,
  parameter int LINE    = 256,
  parameter int BEAT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_i,
  input  logic               b_rd_i,
  output logic [LINE-1:0]    b_data_i,
  output logic               b_dv_i,
  output logic [63:0]        m_addr,
  output logic               m_rd,
  input  logic [BEAT-1:0]    m_data,
  input  logic               m_ack
);

  localparam int N   = LINE / BEAT;
  localparam int KW  = $clog2(N);
  localparam int OFF = $clog2(BEAT / 8);

  typedef enum logic [2:0] {IDLE, FILL, RESP, HOLD, PF} state_t;

  state_t             state_q, state_d;
  logic [BLK_LEN-1:0] blk_q, blk_d;
  logic [KW-1:0]      k_q, k_d;
  logic [LINE-1:0]    line_q, line_d;
  logic [LINE-1:0]    data_q, data_d;
  logic [63:0]        maddr_q, maddr_d;
  logic               last;

`ifdef IMEM_FILL_PREFETCH_EN
  logic               pf_v_q, pf_v_d;
  logic [BLK_LEN-1:0] pf_blk_q, pf_blk_d;
  logic [LINE-1:0]    pf_buf_q, pf_buf_d;
`endif

  function automatic logic [63:0] beat_addr(input logic [BLK_LEN-1:0] b, input logic [KW-1:0] k);
    return 64'({b, k, {OFF{1'b0}}});
  endfunction

  assign last     = (k_q == KW'(N - 1));
  assign m_rd     = (state_q == FILL) || (state_q == PF);
  assign b_dv_i   = (state_q == RESP);
  assign m_addr   = maddr_q;
  assign b_data_i = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      blk_q    <= '0;
      k_q      <= '0;
      line_q   <= '0;
      data_q   <= '0;
      maddr_q  <= '0;
`ifdef IMEM_FILL_PREFETCH_EN
      pf_v_q   <= 1'b0;
      pf_blk_q <= '0;
      pf_buf_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      k_q      <= k_d;
      line_q   <= line_d;
      data_q   <= data_d;
      maddr_q  <= maddr_d;
`ifdef IMEM_FILL_PREFETCH_EN
      pf_v_q   <= pf_v_d;
      pf_blk_q <= pf_blk_d;
      pf_buf_q <= pf_buf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    k_d      = k_q;
    line_d   = line_q;
    data_d   = data_q;
    maddr_d  = maddr_q;
`ifdef IMEM_FILL_PREFETCH_EN
    pf_v_d   = pf_v_q;
    pf_blk_d = pf_blk_q;
    pf_buf_d = pf_buf_q;
`endif
    case (state_q)
      IDLE: begin
        if (b_rd_i) begin
`ifdef IMEM_FILL_PREFETCH_EN
          if (pf_v_q && (b_addr_i == pf_blk_q)) begin
            state_d = RESP;
            blk_d   = b_addr_i;
            data_d  = pf_buf_q;
          end else
`endif
          begin
            state_d = FILL;
            blk_d   = b_addr_i;
            k_d     = '0;
            maddr_d = beat_addr(b_addr_i, '0);
          end
        end
      end
      FILL: begin
        if (m_ack) begin
          line_d[BEAT*k_q +: BEAT] = m_data;
          k_d = k_q + 1'b1;
          // m_addr freezes on the final beat so it holds while m_rd is low
          if (last) begin
            state_d = RESP;
            data_d  = line_d;
          end else begin
            maddr_d = beat_addr(blk_q, k_q + 1'b1);
          end
        end
      end
      RESP: state_d = HOLD;
      HOLD: begin
        state_d = IDLE;
`ifdef IMEM_FILL_PREFETCH_EN
        if (blk_q != '1) begin
          state_d  = PF;
          pf_blk_d = blk_q + 1'b1;
          pf_v_d   = 1'b0;
          k_d      = '0;
          maddr_d  = beat_addr(blk_q + 1'b1, '0);
        end
`endif
      end
`ifdef IMEM_FILL_PREFETCH_EN
      PF: begin
        if (m_ack) begin
          pf_buf_d[BEAT*k_q +: BEAT] = m_data;
          k_d = k_q + 1'b1;
          // a demand for another block abandons the prefetch after this beat
          if (b_rd_i && (b_addr_i != pf_blk_q)) begin
            pf_v_d  = 1'b0;
            state_d = FILL;
            blk_d   = b_addr_i;
            k_d     = '0;
            maddr_d = beat_addr(b_addr_i, '0);
          end else if (last) begin
            if (b_rd_i) begin
              state_d = RESP;
              blk_d   = pf_blk_q;
              data_d  = pf_buf_d;
            end else begin
              state_d = IDLE;
              pf_v_d  = 1'b1;
            end
          end else begin
            maddr_d = beat_addr(pf_blk_q, k_q + 1'b1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fill.sv
// tb/tb_imem_fill.sv - directed self-checking bench for imem_fill
// Prefetch scenarios are compiled only with `IMEM_FILL_PREFETCH_EN.
module tb_imem_fill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [58:0]  b_addr;
  logic         b_rd;
  logic [255:0] b_data;
  logic         b_dv;
  logic [63:0]  m_addr;
  logic         m_rd;
  logic [63:0]  m_data;
  logic         m_ack;

  int checks = 0;
  int errors = 0;
  int wait_cyc = 0;
  int ack_cnt = 0;

  localparam logic [255:0] EXP_200 = 256'hDEADBEEF_00000218_DEADBEEF_00000210_DEADBEEF_00000208_DEADBEEF_00000200;
  localparam logic [255:0] EXP_400 = 256'hDEADBEEF_00000418_DEADBEEF_00000410_DEADBEEF_00000408_DEADBEEF_00000400;
  localparam logic [255:0] EXP_600 = 256'hDEADBEEF_00000618_DEADBEEF_00000610_DEADBEEF_00000608_DEADBEEF_00000600;
`ifdef IMEM_FILL_PREFETCH_EN
  localparam logic [255:0] EXP_220 = 256'hDEADBEEF_00000238_DEADBEEF_00000230_DEADBEEF_00000228_DEADBEEF_00000220;
  localparam logic [255:0] EXP_800 = 256'hDEADBEEF_00000818_DEADBEEF_00000810_DEADBEEF_00000808_DEADBEEF_00000800;
`endif

  imem_fill dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .b_addr_i (b_addr),
    .b_rd_i   (b_rd),
    .b_data_i (b_data),
    .b_dv_i   (b_dv),
    .m_addr   (m_addr),
    .m_rd     (m_rd),
    .m_data   (m_data),
    .m_ack    (m_ack)
  );

  always #5 clk = ~clk;

  // memory: acks each beat after wait_cyc idle cycles, data tags the address
  initial begin
    m_ack = 1'b0;
    m_data = '0;
    forever begin
      @(negedge clk);
      if (m_rd && rst_n) begin
        if (ack_cnt >= wait_cyc) begin
          m_ack = 1'b1;
          m_data = {32'hDEADBEEF, m_addr[31:0]};
          ack_cnt = 0;
        end else begin
          m_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        m_ack = 1'b0;
        ack_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    b_rd = 1'b0;
    b_addr = '0;
    wait_cyc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b_rd = 1'b0;
    b_addr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (b_dv !== 1'b0 || m_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl b_dv=%b m_rd=%b required 0 0", b_dv, m_rd);
    end
    checks++;
    if (m_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_maddr got %h required 0", m_addr);
    end
    checks++;
    if (b_data !== '0) begin
      errors++;
      $display("FAIL reset_bdata got %h required 0", b_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_miss();
    do_reset();
    @(negedge clk);
    b_addr = 59'h10;
    b_rd = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (c <= 4) begin
        if (m_rd !== 1'b1 || m_addr !== 64'h200 + 64'(8 * (c - 1))) begin
          errors++;
          $display("FAIL miss_beat c=%0d m_rd=%b m_addr=%h required 1 %h", c, m_rd, m_addr, 64'h200 + 64'(8 * (c - 1)));
        end
      end else if (m_rd !== 1'b0 || m_addr !== 64'h218) begin
        errors++;
        $display("FAIL miss_idle_bus c=%0d m_rd=%b m_addr=%h required 0 218", c, m_rd, m_addr);
      end
      checks++;
      if (b_dv !== (c == 5)) begin
        errors++;
        $display("FAIL miss_dv c=%0d got %b required %b", c, b_dv, (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (b_data !== EXP_200) begin
          errors++;
          $display("FAIL miss_data got %h required %h", b_data, EXP_200);
        end
        b_rd = 1'b0;
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    wait_cyc = 3;
    @(negedge clk);
    b_addr = 59'h10;
    b_rd = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h200 + 64'(8 * ((c - 1) / 4))) begin
          errors++;
          $display("FAIL wait_beat c=%0d m_rd=%b m_addr=%h required 1 %h", c, m_rd, m_addr, 64'h200 + 64'(8 * ((c - 1) / 4)));
        end
      end
      checks++;
      if (b_dv !== (c == 17)) begin
        errors++;
        $display("FAIL wait_dv c=%0d got %b required %b", c, b_dv, (c == 17));
      end
      if (c == 17) begin
        checks++;
        if (b_data !== EXP_200) begin
          errors++;
          $display("FAIL wait_data got %h required %h", b_data, EXP_200);
        end
        b_rd = 1'b0;
      end
    end
    wait_cyc = 0;
  endtask

  task automatic test_reset_mid_fill();
    logic dv_seen;
    do_reset();
    @(negedge clk);
    b_addr = 59'h10;
    b_rd = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (m_addr !== 64'h210) begin
      errors++;
      $display("FAIL midrst_pre m_addr=%h required 210", m_addr);
    end
    rst_n = 1'b0;
    b_rd = 1'b0;
    #1;
    checks++;
    if (m_rd !== 1'b0 || b_dv !== 1'b0 || m_addr !== 64'h0) begin
      errors++;
      $display("FAIL midrst_async m_rd=%b b_dv=%b m_addr=%h required 0 0 0", m_rd, b_dv, m_addr);
    end
    dv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b_dv !== 1'b0) dv_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (b_dv !== 1'b0) dv_seen = 1'b1;
    end
    checks++;
    if (dv_seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_dv got %b required 0", dv_seen);
    end
    b_addr = 59'h20;
    b_rd = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h400 + 64'(8 * (c - 1))) begin
          errors++;
          $display("FAIL midrst_beat c=%0d m_rd=%b m_addr=%h required 1 %h", c, m_rd, m_addr, 64'h400 + 64'(8 * (c - 1)));
        end
      end else begin
        checks++;
        if (b_dv !== 1'b1 || b_data !== EXP_400) begin
          errors++;
          $display("FAIL midrst_resp b_dv=%b b_data=%h required 1 %h", b_dv, b_data, EXP_400);
        end
        b_rd = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int dv_cnt;
    int dv_c1;
    int dv_c2;
    dv_cnt = 0;
    dv_c1 = 0;
    dv_c2 = 0;
    do_reset();
    @(negedge clk);
    b_addr = 59'h10;
    b_rd = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
`ifndef IMEM_FILL_PREFETCH_EN
      if (c == 7) begin
        checks++;
        if (m_rd !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold_ignored m_rd=%b required 0", m_rd);
        end
      end
`endif
      if (c == 8) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h600) begin
          errors++;
          $display("FAIL b2b_second_fill m_rd=%b m_addr=%h required 1 600", m_rd, m_addr);
        end
      end
      if (b_dv === 1'b1) begin
        dv_cnt++;
        if (dv_cnt == 1) dv_c1 = c;
        if (dv_cnt == 2) begin
          dv_c2 = c;
          checks++;
          if (b_data !== EXP_600) begin
            errors++;
            $display("FAIL b2b_data2 got %h required %h", b_data, EXP_600);
          end
        end
        b_rd = 1'b0;
      end
      if (c == 6) begin
        b_addr = 59'h30;
        b_rd = 1'b1;
      end
    end
    checks++;
    if (dv_cnt != 2 || dv_c1 != 5 || dv_c2 != 12) begin
      errors++;
      $display("FAIL b2b_dv count=%0d cycles=%0d,%0d required 2 at 5,12", dv_cnt, dv_c1, dv_c2);
    end
  endtask

`ifdef IMEM_FILL_PREFETCH_EN
  task automatic test_prefetch_hit();
    do_reset();
    @(negedge clk);
    b_addr = 59'h10;
    b_rd = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 5) b_rd = 1'b0;
      if (c >= 7 && c <= 10) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h220 + 64'(8 * (c - 7))) begin
          errors++;
          $display("FAIL pf_beat c=%0d m_rd=%b m_addr=%h required 1 %h", c, m_rd, m_addr, 64'h220 + 64'(8 * (c - 7)));
        end
      end
      if (c == 11) begin
        checks++;
        if (m_rd !== 1'b0 || b_dv !== 1'b0) begin
          errors++;
          $display("FAIL pf_idle m_rd=%b b_dv=%b required 0 0", m_rd, b_dv);
        end
        b_addr = 59'h11;
        b_rd = 1'b1;
      end
      if (c == 12) begin
        checks++;
        if (b_dv !== 1'b1 || m_rd !== 1'b0 || b_data !== EXP_220) begin
          errors++;
          $display("FAIL pf_hit b_dv=%b m_rd=%b b_data=%h required 1 0 %h", b_dv, m_rd, b_data, EXP_220);
        end
        b_rd = 1'b0;
      end
      if (c == 14) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h240) begin
          errors++;
          $display("FAIL pf_next m_rd=%b m_addr=%h required 1 240", m_rd, m_addr);
        end
      end
    end
  endtask

  task automatic test_prefetch_abort();
    do_reset();
    @(negedge clk);
    b_addr = 59'h10;
    b_rd = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 5) b_rd = 1'b0;
      if (c == 7) begin
        b_addr = 59'h40;
        b_rd = 1'b1;
      end
      if (c == 8) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h800) begin
          errors++;
          $display("FAIL pfab_demand m_rd=%b m_addr=%h required 1 800", m_rd, m_addr);
        end
      end
      if (c == 12) begin
        checks++;
        if (b_dv !== 1'b1 || b_data !== EXP_800) begin
          errors++;
          $display("FAIL pfab_resp b_dv=%b b_data=%h required 1 %h", b_dv, b_data, EXP_800);
        end
        b_rd = 1'b0;
      end
      if (c == 14) begin
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 64'h820) begin
          errors++;
          $display("FAIL pfab_pf2 m_rd=%b m_addr=%h required 1 820", m_rd, m_addr);
        end
        b_addr = 59'h11;
        b_rd = 1'b1;
      end
      if (c == 15) begin
        checks++;
        if (b_dv !== 1'b0 || m_rd !== 1'b1 || m_addr !== 64'h220) begin
          errors++;
          $display("FAIL pfab_miss b_dv=%b m_rd=%b m_addr=%h required 0 1 220", b_dv, m_rd, m_addr);
        end
      end
      if (c == 19) begin
        checks++;
        if (b_dv !== 1'b1 || b_data !== EXP_220) begin
          errors++;
          $display("FAIL pfab_resp2 b_dv=%b b_data=%h required 1 %h", b_dv, b_data, EXP_220);
        end
        b_rd = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_wait_states();
    test_reset_mid_fill();
    test_back_to_back();
`ifdef IMEM_FILL_PREFETCH_EN
    test_prefetch_hit();
    test_prefetch_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
